// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, the NOP encoding and the fetch FSM state type.
// The state type lives here so debug/trace logic can decode it too.
package cpu_pkg;

  localparam logic [3:0]  OP_BLT    = 4'b0100;
  localparam logic [3:0]  OP_BGT    = 4'b0101;
  localparam logic [3:0]  OP_BEQ    = 4'b0110;
  localparam logic [3:0]  OP_HALT   = 4'b1111;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold and flush. Flush inserts a bubble (zero instr,
// valid low) and keeps the captured PC; hold wins over flush and load.
module if_id_reg #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      if (flush_i) begin
        instr_q <= '0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, branch-target adder, RUN/HALT FSM and the IF/ID register.
// Stall outranks branch, branch outranks a fetched HALT; HALT exits only on reset.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0] branch_target;
  logic              fetched_halt;
  logic              flush;

  assign branch_target = if_id_pc + ADDR_W'(1) + branch_offset;
  assign fetched_halt  = (imem_rdata[INSTR_W-1 -: 4] == OP_HALT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush         = 1'b0;
    fetch_count_d = fetch_count_q;
    if (!stall) begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            pc_d  = branch_target;
            flush = 1'b1;
          end else if (fetched_halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
        ST_HALT: flush = 1'b1;
        default: flush = 1'b1;
      endcase
      if (!flush) fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall),
    .flush_i (flush),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage 16-bit CPU. It holds the program counter, drives the instruction-memory address and registers the fetched instruction for decode. It consumes the branch-taken decision resolved in ID by the branch comparator, redirecting the PC and flushing the wrong-path instruction. It also stops fetching on a HALT opcode.

## Interface
- `ADDR_W`, 16, PC / instruction-memory address width (word-addressed)
- `INSTR_W`, 16, instruction width; opcode is `[INSTR_W-1 -: 4]`
- `RESET_PC`, 16'h0000, PC value after reset

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard-unit hold of PC and IF/ID
- `branch_taken`  in  1  branch comparator result for the instruction now in IF/ID
- `branch_offset`  in  ADDR_W  sign-extended branch immediate from ID
- `imem_addr`  out  ADDR_W  instruction-memory address; combinational copy of PC
- `imem_rdata`  in  INSTR_W  instruction word; asynchronous read, valid same cycle
- `if_id_instr`  out  INSTR_W  registered instruction to ID
- `if_id_pc`  out  ADDR_W  PC of `if_id_instr`
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble
- `halted`  out  1  FSM in HALT
- `fetch_count`  out  16  number of valid instructions loaded into IF/ID

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Branch target = `if_id_pc + 1 + branch_offset`, modulo 2^ADDR_W (wrap, no overflow flag).
- Per-cycle priority (highest first):
  1. `stall=1`: PC, IF/ID, FSM and `fetch_count` all hold. `branch_taken` is ignored, because the hazard unit re-presents the branch next cycle.
  2. RUN and `branch_taken=1`:
     - PC <= target.
     - IF/ID <= bubble (`instr=16'h0000`, `valid=0`, `pc` holds).
     - FSM stays RUN, even if `imem_rdata` is HALT.
  3. RUN and fetched opcode == HALT (4'b1111):
     - IF/ID <= HALT instruction, valid=1.
     - PC holds.
     - FSM -> HALT.
  4. RUN otherwise: IF/ID <= {`imem_rdata`, PC, 1}; PC <= PC+1 (wraps 16'hFFFF -> 0).
  5. HALT: PC holds; IF/ID <= bubble; `branch_taken` is ignored. HALT exits only through reset.
- `fetch_count` increments (wrapping) on every edge that loads IF/ID with `valid=1`.
- `halted` = (state == HALT).

## Timing
- Reset (async assert, any cycle, including mid-branch or mid-stall):
  - PC = RESET_PC, so `imem_addr` = RESET_PC immediately.
  - `if_id_instr` = 0, `if_id_pc` = 0, `if_id_valid` = 0.
  - `halted` = 0, `fetch_count` = 0, state RUN.
- Release of reset is synchronous to `clk`. The first fetch is registered at the first rising edge with `rst_n=1`.
- Fetch latency: an instruction at address A appears on `if_id_instr` one edge after PC=A.
- Taken branch:
  - One bubble (one-cycle penalty).
  - The target instruction is in IF/ID two edges after the branch was in IF/ID.
- Stall: zero-latency hold. Outputs are unchanged for every stalled cycle.
- `imem_addr` has no register stage. It changes only at clock edges or on reset.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_BLT=4'b0100`, `OP_BGT=4'b0101`, `OP_BEQ=4'b0110`, `OP_HALT=4'b1111`
  - `NOP_INSTR=16'h0000`
  - the FSM state enum, shared with debug/trace logic.
- One sub-module is natural: `if_id_reg`, the IF/ID register with hold (stall) and flush (bubble) controls, reusable for the other pipeline registers.
- The PC, the target adder and the FSM stay in `fetch_stage`.

## Test plan
- Reset/linear fetch: memory holds 0x1001, 0x1002, 0x1003 at 0..2; release reset.
  - Expect `if_id_instr` = 0x1001/0x1002/0x1003 with `if_id_pc` = 0/1/2 on successive edges.
  - Expect `fetch_count` = 3.
- Taken branch: with `if_id_pc`=4 and `branch_offset`=16'hFFFD (−3), pulse `branch_taken`.
  - Expect the next edge to give PC=2, `if_id_valid`=0.
  - Expect the following edge to give `if_id_pc`=2, valid=1.
- Stall vs branch: `stall=1` and `branch_taken=1` together for 2 cycles.
  - Expect PC, IF/ID and `fetch_count` unchanged.
  - After stall drops with `branch_taken=1`, expect the redirect to occur.
- HALT: 0xF000 at address 3.
  - Expect `if_id_instr`=0xF000, then `halted`=1 and PC frozen at 3.
  - Expect bubbles afterwards; a `branch_taken` pulse has no effect.
- Branch beats halt: branch in IF/ID while `imem_rdata`=0xF000 and `branch_taken`=1.
  - Expect a redirect, `halted`=0, and a bubble in IF/ID.
- Wrap and async reset: `RESET_PC`=16'hFFFF.
  - Expect `if_id_pc`=16'hFFFF, then 0.
  - Assert `rst_n` low between edges: expect all outputs to reset immediately, without waiting for a clock edge.
